// File: rtl/shared_reg_arbiter_pkg.sv
// shared_reg_arb_pkg: shared types, constants and the round-robin wrap helper.
//   arb_state_e : IDLE / HOLD arbiter states
//   STATS_W     : width of the optional write counter (SHARED_REG_ARB_STATS_EN)
//   rr_wrap     : folds an index in [0, 2*n) back into [0, n)
package shared_reg_arb_pkg;
    typedef enum logic {IDLE, HOLD} arb_state_e;
    localparam int STATS_W = 16;
    function automatic int rr_wrap(input int i, input int n);
        return (i >= n) ? i - n : i;
    endfunction
endpackage

// File: rtl/shared_reg_arbiter_if.sv
// shared_reg_arbiter_if: valid/ready write-request bus from NUM_REQ producers.
//   req_valid [NUM_REQ]       : per-requester write request
//   req_data  [NUM_REQ*WIDTH] : requester i at bits [i*WIDTH +: WIDTH]
//   req_ready [NUM_REQ]       : one-hot accept from the arbiter
//   master = producers, slave = arbiter
interface shared_reg_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/shared_reg_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search starting at ptr.
//   req_valid    : in,  request vector
//   ptr          : in,  highest-priority index
//   grant_onehot : out, one-hot winner (zero when nothing valid)
//   grant_idx    : out, winner index
//   any_valid    : out, at least one request present
module rr_picker
    import shared_reg_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_valid
);
    int idx;
    always_comb begin
        idx          = 0;
        grant_onehot = '0;
        grant_idx    = '0;
        any_valid    = 1'b0;
        // Scan from the farthest offset back to ptr so the nearest valid one wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = rr_wrap(int'(ptr) + k, NUM_REQ);
            if (req_valid[idx]) begin
                grant_idx = idx[IDX_W-1:0];
                any_valid = 1'b1;
            end
        end
        grant_onehot[grant_idx] = any_valid;
    end
endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin write arbiter for one shared register.
//   clk, rst_n  : clock, synchronous active-low reset
//   bus         : request bus (slave side of shared_reg_arbiter_if)
//   q           : shared register contents
//   last_owner  : index of the last committed requester
//   busy        : high while locked after a commit
//   write_count : saturating commit counter, only with SHARED_REG_ARB_STATS_EN
module shared_reg_arbiter
    import shared_reg_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    shared_reg_arbiter_if.slave        bus,
    output logic [WIDTH-1:0]           q,
    output logic [$clog2(NUM_REQ)-1:0] last_owner,
`ifdef SHARED_REG_ARB_STATS_EN
    output logic [STATS_W-1:0]         write_count,
`endif
    output logic                       busy
);
    localparam int IDX_W = $clog2(NUM_REQ);
    arb_state_e       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0] owner_q, owner_d, ptr_q, ptr_d, grant_idx;
    logic [NUM_REQ-1:0] grant_onehot;
    logic any_valid, fire;
    rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .req_valid    (bus.req_valid),
        .ptr          (ptr_q),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any_valid    (any_valid)
    );
    // The grant only ever targets a valid requester, so any grant is a handshake.
    assign fire          = rst_n && state_q == IDLE && any_valid;
    assign bus.req_ready = (rst_n && state_q == IDLE) ? grant_onehot : '0;
    assign q             = data_q;
    assign last_owner    = owner_q;
    assign busy          = state_q == HOLD;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (fire) begin
            data_d  = bus.req_data[int'(grant_idx)*WIDTH +: WIDTH];
            owner_d = grant_idx;
            ptr_d   = IDX_W'(rr_wrap(int'(grant_idx) + 1, NUM_REQ));
            if (HOLD_CYCLES > 0) begin
                state_d = HOLD;
                cnt_d   = 8'(HOLD_CYCLES);
            end
        end else if (state_q == HOLD) begin
            cnt_d   = cnt_q - 8'd1;
            state_d = (cnt_q == 8'd1) ? IDLE : HOLD;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end
`ifdef SHARED_REG_ARB_STATS_EN
    logic [STATS_W-1:0] wc_q, wc_d;
    assign wc_d        = (fire && wc_q != '1) ? wc_q + 1'b1 : wc_q;
    assign write_count = wc_q;
    always_ff @(posedge clk) begin
        if (!rst_n) wc_q <= '0;
        else        wc_q <= wc_d;
    end
`endif
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: table-driven round-robin checks on a HOLD_CYCLES=0 instance,
// hand-written hold/reset sequences on a HOLD_CYCLES=3 instance.
module tb_shared_reg_arbiter;
    import shared_reg_arb_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shared_reg_arbiter_if #(.NUM_REQ(4), .WIDTH(8)) if0 ();
    shared_reg_arbiter_if #(.NUM_REQ(4), .WIDTH(8)) if3 ();
    logic [7:0] q0, q3;
    logic [1:0] own0, own3;
    logic       busy0, busy3;
`ifdef SHARED_REG_ARB_STATS_EN
    logic [15:0] wc0, wc3;
`endif

    shared_reg_arbiter #(.NUM_REQ(4), .WIDTH(8), .HOLD_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave), .q(q0), .last_owner(own0),
`ifdef SHARED_REG_ARB_STATS_EN
        .write_count(wc0),
`endif
        .busy(busy0)
    );
    shared_reg_arbiter #(.NUM_REQ(4), .WIDTH(8), .HOLD_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(if3.slave), .q(q3), .last_owner(own3),
`ifdef SHARED_REG_ARB_STATS_EN
        .write_count(wc3),
`endif
        .busy(busy3)
    );

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  rdy;
        logic [7:0]  qn;
        logic [1:0]  own;
    } vec_t;
    typedef struct {
        logic [7:0] q;
        logic [1:0] own;
        int         row;
    } exp_t;

    vec_t tbl[14];
    exp_t sb[$];
    exp_t e;
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    localparam logic [31:0] D0 = 32'hA3A2A1A0;

    initial begin
        tbl[0]  = '{4'hF, D0, 4'h1, 8'hA0, 2'd0};
        tbl[1]  = '{4'hF, D0, 4'h2, 8'hA1, 2'd1};
        tbl[2]  = '{4'hF, D0, 4'h4, 8'hA2, 2'd2};
        tbl[3]  = '{4'hF, D0, 4'h8, 8'hA3, 2'd3};
        tbl[4]  = '{4'hF, D0, 4'h1, 8'hA0, 2'd0};
        tbl[5]  = '{4'h4, D0, 4'h4, 8'hA2, 2'd2};
        tbl[6]  = '{4'h4, 32'hA35CA1A0, 4'h4, 8'h5C, 2'd2};
        tbl[7]  = '{4'hF, D0, 4'h8, 8'hA3, 2'd3};
        tbl[8]  = '{4'h0, D0, 4'h0, 8'hA3, 2'd3};
        tbl[9]  = '{4'h3, D0, 4'h1, 8'hA0, 2'd0};
        tbl[10] = '{4'h3, D0, 4'h2, 8'hA1, 2'd1};
        tbl[11] = '{4'h3, D0, 4'h1, 8'hA0, 2'd0};
        tbl[12] = '{4'h8, D0, 4'h8, 8'hA3, 2'd3};
        tbl[13] = '{4'h0, D0, 4'h0, 8'hA3, 2'd3};

        // Reset with every requester asserting.
        if0.req_valid = 4'hF; if0.req_data = D0;
        if3.req_valid = 4'h0; if3.req_data = D0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", q0, 8'h00);
        check("rst_ready", if0.req_ready, 4'h0);
        check("rst_busy", busy0, 1'b0);
        check("rst_owner", own0, 2'd0);
        rst_n = 1'b1;

        // Table: one row per cycle; q/owner checked on the following cycle via the scoreboard.
        for (int i = 0; i < 14; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("q_row%0d", e.row), q0, e.q);
                check($sformatf("owner_row%0d", e.row), own0, e.own);
            end
            if0.req_valid = tbl[i].v;
            if0.req_data  = tbl[i].d;
            #4;
            check($sformatf("ready_row%0d", i), if0.req_ready, tbl[i].rdy);
            check($sformatf("busy0_row%0d", i), busy0, 1'b0);
            sb.push_back('{tbl[i].qn, tbl[i].own, i});
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check($sformatf("q_row%0d", e.row), q0, e.q);
        check($sformatf("owner_row%0d", e.row), own0, e.own);
        if0.req_valid = 4'h0;

        // HOLD_CYCLES=3: three locked cycles, next grant in the fourth.
        if3.req_valid = 4'hF;
        #4;
        check("hold_first_ready", if3.req_ready, 4'h1);
        check("hold_first_busy", busy3, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                check("hold_commit_q", q3, 8'hA0);
                check("hold_commit_owner", own3, 2'd0);
            end
            #4;
            check($sformatf("hold_busy%0d", k), busy3, 1'b1);
            check($sformatf("hold_ready%0d", k), if3.req_ready, 4'h0);
        end
        @(posedge clk);
        #5;
        check("hold_release_busy", busy3, 1'b0);
        check("hold_release_ready", if3.req_ready, 4'h2);
        @(posedge clk);
        #1;
        check("hold_second_q", q3, 8'hA1);
        #4;
        check("hold_second_busy", busy3, 1'b1);

        // Reset lands mid-HOLD with requests still pending.
        rst_n = 1'b0;
        #1;
        check("rst_hold_ready_comb", if3.req_ready, 4'h0);
        @(posedge clk);
        #1;
        check("rst_hold_q", q3, 8'h00);
        check("rst_hold_busy", busy3, 1'b0);
        check("rst_hold_owner", own3, 2'd0);
        check("rst_hold_q0", q0, 8'h00);
        rst_n = 1'b1;
        #4;
        check("rst_hold_regrant", if3.req_ready, 4'h1);
        check("rst_hold_no_commit", q3, 8'h00);
        @(posedge clk);
        #1;
        check("rst_hold_post_q", q3, 8'hA0);

`ifdef SHARED_REG_ARB_STATS_EN
        if3.req_valid = 4'h0;
        if0.req_valid = 4'hF;
        repeat (70000) @(posedge clk);
        #1;
        check("stats_sat", wc0, 16'hFFFF);
        @(posedge clk);
        #1;
        check("stats_hold", wc0, 16'hFFFF);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("stats_rst", wc0, 16'h0000);
        rst_n = 1'b1;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
